// File: rtl/intersection_sequencer.sv
// intersection_sequencer
//   Two-approach (north-south / east-west) traffic intersection controller.
//   Each approach runs green -> flash_green -> yellow, separated by an all-red
//   clearance interval. Green length adapts to latched vehicle and pedestrian
//   requests. A walk indication is given during an all-red interval when a
//   pedestrian request was pending on entry to that interval.
//
//   Optional feature (macro NIGHT_FLASH_EN): adds a NIGHT state entered from
//   ALL_RED_B while `night` is high, showing NS yellow / EW red and a blink
//   indicator toggling every T_FLASH cycles.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   ns_req       in   NS vehicle sensor (level or pulse)
//   ew_req       in   EW vehicle sensor (level or pulse)
//   ped_req      in   pedestrian button (level or pulse)
//   night        in   night mode request           (NIGHT_FLASH_EN only)
//   ns_light     out  NS lamp: 00 green, 01 flash_green, 11 yellow, 10 red
//   ew_light     out  EW lamp, same encoding
//   ped_walk     out  walk indication
//   night_blink  out  night blink indicator        (NIGHT_FLASH_EN only)
//   phase        out  current state code

module intersection_sequencer #(
    parameter int CNT_W       = 8,
    parameter int T_GREEN_MIN = 8,
    parameter int T_GREEN_MAX = 32,
    parameter int T_FLASH     = 4,
    parameter int T_YELLOW    = 4,
    parameter int T_ALLRED    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ns_req,
    input  logic       ew_req,
    input  logic       ped_req,
`ifdef NIGHT_FLASH_EN
    input  logic       night,
    output logic       night_blink,
`endif
    output logic [1:0] ns_light,
    output logic [1:0] ew_light,
    output logic       ped_walk,
    output logic [3:0] phase
);

    typedef enum logic [3:0] {
        NS_GREEN  = 4'd0,
        NS_FLASH  = 4'd1,
        NS_YELLOW = 4'd2,
        ALL_RED_A = 4'd3,
        EW_GREEN  = 4'd4,
        EW_FLASH  = 4'd5,
        EW_YELLOW = 4'd6,
        ALL_RED_B = 4'd7
`ifdef NIGHT_FLASH_EN
        ,
        NIGHT     = 4'd8
`endif
    } state_t;

    localparam logic [1:0] LAMP_GREEN  = 2'b00;
    localparam logic [1:0] LAMP_FLASH  = 2'b01;
    localparam logic [1:0] LAMP_YELLOW = 2'b11;
    localparam logic [1:0] LAMP_RED    = 2'b10;

    localparam logic [CNT_W-1:0] GMIN_LAST   = CNT_W'(T_GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_LAST   = CNT_W'(T_GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] FLASH_LAST  = CNT_W'(T_FLASH - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(T_ALLRED - 1);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] timer;
    logic             ns_pend;
    logic             ew_pend;
    logic             ped_pend;
    // ped request seen during a walk interval; handed to ped_pend when the
    // interval ends so it is served in the following all-red state
    logic             ped_hold;
    logic             walk;
`ifdef NIGHT_FLASH_EN
    logic             blink;
`endif

    logic state_change;
    logic ns_green_exit;
    logic ew_green_exit;
    logic in_all_red;
    logic next_all_red;

    assign state_change = (next_state != state);
    assign in_all_red   = (state == ALL_RED_A) || (state == ALL_RED_B);
    assign next_all_red = (next_state == ALL_RED_A) || (next_state == ALL_RED_B);

    // Early exit needs a cross-approach or pedestrian demand after the minimum
    assign ns_green_exit = ((timer >= GMIN_LAST) && (ew_pend || ped_pend)) ||
                           (timer == GMAX_LAST);
    assign ew_green_exit = ((timer >= GMIN_LAST) && (ns_pend || ped_pend)) ||
                           (timer == GMAX_LAST);

    always_comb begin
        next_state = state;
        case (state)
            NS_GREEN:  if (ns_green_exit)        next_state = NS_FLASH;
            NS_FLASH:  if (timer == FLASH_LAST)  next_state = NS_YELLOW;
            NS_YELLOW: if (timer == YELLOW_LAST) next_state = ALL_RED_A;
            ALL_RED_A: if (timer == ALLRED_LAST) next_state = EW_GREEN;
            EW_GREEN:  if (ew_green_exit)        next_state = EW_FLASH;
            EW_FLASH:  if (timer == FLASH_LAST)  next_state = EW_YELLOW;
            EW_YELLOW: if (timer == YELLOW_LAST) next_state = ALL_RED_B;
            ALL_RED_B: begin
                if (timer == ALLRED_LAST) begin
`ifdef NIGHT_FLASH_EN
                    next_state = night ? NIGHT : NS_GREEN;
`else
                    next_state = NS_GREEN;
`endif
                end
            end
`ifdef NIGHT_FLASH_EN
            NIGHT:     if (!night)               next_state = ALL_RED_B;
`endif
            default:                             next_state = ALL_RED_B;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ALL_RED_B;
            timer    <= '0;
            ns_pend  <= 1'b0;
            ew_pend  <= 1'b0;
            ped_pend <= 1'b0;
            ped_hold <= 1'b0;
            walk     <= 1'b0;
`ifdef NIGHT_FLASH_EN
            blink    <= 1'b0;
`endif
        end else begin
            state <= next_state;

            if (state_change) begin
                timer <= '0;
`ifdef NIGHT_FLASH_EN
            end else if ((state == NIGHT) && (timer == FLASH_LAST)) begin
                // restart per blink half-period so the timer cannot wrap
                timer <= '0;
`endif
            end else begin
                timer <= timer + CNT_W'(1);
            end

            // Clear on green entry takes priority over a same-edge request
            ns_pend <= (state_change && next_state == NS_GREEN) ? 1'b0 : (ns_pend | ns_req);
            ew_pend <= (state_change && next_state == EW_GREEN) ? 1'b0 : (ew_pend | ew_req);

            if (state_change && in_all_red && walk) begin
                ped_pend <= ped_hold | ped_req;
                ped_hold <= 1'b0;
            end else begin
                ped_pend <= ped_pend | ped_req;
                ped_hold <= ped_hold | (walk & ped_req);
            end

            // Walk decision is taken from ped_pend as it stood before this edge
            if (state_change) begin
                walk <= next_all_red & ped_pend;
            end

`ifdef NIGHT_FLASH_EN
            if (state_change && next_state == NIGHT) begin
                blink <= 1'b1;
            end else if ((state == NIGHT) && (timer == FLASH_LAST)) begin
                blink <= ~blink;
            end
`endif
        end
    end

    always_comb begin
        ns_light = LAMP_RED;
        ew_light = LAMP_RED;
        case (state)
            NS_GREEN:  ns_light = LAMP_GREEN;
            NS_FLASH:  ns_light = LAMP_FLASH;
            NS_YELLOW: ns_light = LAMP_YELLOW;
            EW_GREEN:  ew_light = LAMP_GREEN;
            EW_FLASH:  ew_light = LAMP_FLASH;
            EW_YELLOW: ew_light = LAMP_YELLOW;
`ifdef NIGHT_FLASH_EN
            NIGHT:     ns_light = LAMP_YELLOW;
`endif
            default: begin
                ns_light = LAMP_RED;
                ew_light = LAMP_RED;
            end
        endcase
    end

    assign ped_walk = walk;
    assign phase    = state;
`ifdef NIGHT_FLASH_EN
    assign night_blink = (state == NIGHT) & blink;
`endif

endmodule

// File: tb/tb_intersection_sequencer.sv
// Directed bench for intersection_sequencer (default build, default parameters).
module tb_intersection_sequencer;

    logic       clk;
    logic       rst_n;
    logic       ns_req;
    logic       ew_req;
    logic       ped_req;
    logic [1:0] ns_light;
    logic [1:0] ew_light;
    logic       ped_walk;
    logic [3:0] phase;

    int checks = 0;
    int errors = 0;

    intersection_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ns_req   (ns_req),
        .ew_req   (ew_req),
        .ped_req  (ped_req),
        .ns_light (ns_light),
        .ew_light (ew_light),
        .ped_walk (ped_walk),
        .phase    (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_st(input string tag, input logic [3:0] ph, input logic [1:0] ns,
                          input logic [1:0] ew, input logic wk);
        chk({tag, ".phase"}, 32'(phase), 32'(ph));
        chk({tag, ".ns"}, 32'(ns_light), 32'(ns));
        chk({tag, ".ew"}, 32'(ew_light), 32'(ew));
        chk({tag, ".walk"}, 32'(ped_walk), 32'(wk));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; ns_req = 1'b0; ew_req = 1'b0; ped_req = 1'b0;
        step(2);
        chk_st("reset", 4'd7, 2'b10, 2'b10, 1'b0);

        // Idle cycle: 2 all-red, then full-length phases
        rst_n = 1'b1;
        step(1);  chk_st("rel_ar1", 4'd7, 2'b10, 2'b10, 1'b0);
        step(1);  chk_st("ns_g0", 4'd0, 2'b00, 2'b10, 1'b0);
        step(31); chk_st("ns_g31", 4'd0, 2'b00, 2'b10, 1'b0);
        step(1);  chk_st("ns_fl", 4'd1, 2'b01, 2'b10, 1'b0);
        step(4);  chk_st("ns_ye", 4'd2, 2'b11, 2'b10, 1'b0);
        step(4);  chk_st("ar_a", 4'd3, 2'b10, 2'b10, 1'b0);
        step(2);  chk_st("ew_g0", 4'd4, 2'b10, 2'b00, 1'b0);

        // ped_req pulse at EW timer 1 -> EW green 8, walk in ALL_RED_B
        step(1);
        ped_req = 1'b1; step(1); ped_req = 1'b0;
        step(5);  chk_st("ped_ew_g7", 4'd4, 2'b10, 2'b00, 1'b0);
        step(1);  chk_st("ped_ew_fl", 4'd5, 2'b10, 2'b01, 1'b0);
        step(4);  chk_st("ped_ew_ye", 4'd6, 2'b10, 2'b11, 1'b0);
        step(4);  chk_st("ped_arb0", 4'd7, 2'b10, 2'b10, 1'b1);
        step(1);  chk_st("ped_arb1", 4'd7, 2'b10, 2'b10, 1'b1);
        step(1);  chk_st("ped_ns_g0", 4'd0, 2'b00, 2'b10, 1'b0);
        // ped_pend cleared: NS green runs full length
        step(31); chk("ped_clr_g31", 32'(phase), 32'd0);
        step(1);  chk("ped_clr_fl", 32'(phase), 32'd1);

        // Idle round to NS green
        step(10); chk("idle_ew", 32'(phase), 32'd4);
        step(42); chk("idle_ns", 32'(phase), 32'd0);

        // ew_req pulse at NS timer 2 -> NS green 8
        step(2);
        ew_req = 1'b1; step(1); ew_req = 1'b0;
        step(4);  chk("ew2_g7", 32'(phase), 32'd0);
        step(1);  chk("ew2_fl", 32'(phase), 32'd1);
        step(10); chk("ew2_ewg", 32'(phase), 32'd4);
        step(42); chk("ew2_nsg", 32'(phase), 32'd0);
        // ew_pend cleared on EW green entry: no cut at timer 8
        step(8);  chk("ew_clr_g8", 32'(phase), 32'd0);

        // ew_req pulse at NS timer 20 -> NS green 22
        step(12);
        ew_req = 1'b1; step(1); ew_req = 1'b0;
        chk("ew20_g21", 32'(phase), 32'd0);
        step(1);  chk_st("ew20_fl", 4'd1, 2'b01, 2'b10, 1'b0);
        step(4);  chk_st("ew20_ye", 4'd2, 2'b11, 2'b10, 1'b0);
        step(4);  chk_st("ew20_ara", 4'd3, 2'b10, 2'b10, 1'b0);
        step(2);  chk("ew20_ewg", 32'(phase), 32'd4);

        // ns_req held high: EW green cut to 8 on every round
        ns_req = 1'b1;
        step(7);  chk("nsh_ew_g7", 32'(phase), 32'd4);
        step(1);  chk("nsh_ew_fl", 32'(phase), 32'd5);
        step(10); chk("nsh_ns_g0", 32'(phase), 32'd0);
        step(31); chk("nsh_ns_g31", 32'(phase), 32'd0);
        step(1);  chk("nsh_ns_fl", 32'(phase), 32'd1);
        step(10); chk("nsh_ew2_g0", 32'(phase), 32'd4);
        step(7);  chk("nsh_ew2_g7", 32'(phase), 32'd4);
        step(1);  chk("nsh_ew2_fl", 32'(phase), 32'd5);
        ns_req = 1'b0;

        // Reset during EW_YELLOW with a pending EW request
        step(4);  chk_st("pre_rst_ye", 4'd6, 2'b10, 2'b11, 1'b0);
        ew_req = 1'b1; step(1); ew_req = 1'b0;
        rst_n = 1'b0;
        #1;       chk_st("async_rst", 4'd7, 2'b10, 2'b10, 1'b0);
        step(2);  chk("rst_hold", 32'(phase), 32'd7);
        rst_n = 1'b1;
        step(1);  chk("rst2_ar", 32'(phase), 32'd7);
        step(1);  chk("rst2_nsg", 32'(phase), 32'd0);
        // pending EW request was lost: NS green full length
        step(31); chk("rst2_g31", 32'(phase), 32'd0);
        step(1);  chk("rst2_fl", 32'(phase), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
